// File: rtl/falling_block_gen.sv
// Falling-block generator: spawns a block at a pseudo-random column and color,
// lowers it at a fixed rate, and retires it on collision or at the floor.
module falling_block_gen #(
  parameter int          TICK_DIV      = 250000,
  parameter int          FALL_STEP     = 2,
  parameter int          SPAWN_Y       = 0,
  parameter int          FLOOR_Y       = 480,
  parameter int          X_MIN         = 0,
  parameter int          X_MAX         = 490,
  parameter int          RESPAWN_DELAY = 25000000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter logic [9:0]  PARK          = 10'h3FF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       collision,
  output logic [9:0] fall_x,
  output logic [9:0] fall_y,
  output logic [1:0] fall_color,
  output logic       active,
  output logic       spawned,
  output logic       caught,
  output logic       missed
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WW = (RESPAWN_DELAY > 0) ? $clog2(RESPAWN_DELAY + 1) : 1;

  typedef enum logic {WAIT, FALL} state_t;

  state_t         state_q, state_d;
  logic [WW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [TW-1:0]  tick_q, tick_d;
  logic [15:0]    lfsr_q, lfsr_d;
  logic [9:0]     x_q, x_d;
  logic [9:0]     y_q, y_d;
  logic [1:0]     color_q, color_d;
  logic           active_q, active_d;
  logic           spawned_q, spawned_d;
  logic           caught_q, caught_d;
  logic           missed_q, missed_d;

  logic [10:0]    raw_x;
  logic [9:0]     spawn_x;
  logic [1:0]     spawn_color;
  logic [10:0]    y_next;
  logic [15:0]    lfsr_adv;
  logic           retire;

  // Column folds back by one span when the 9-bit draw overshoots X_MAX.
  assign raw_x       = 11'(X_MIN) + {2'b00, lfsr_q[8:0]};
  assign spawn_x     = (raw_x > 11'(X_MAX)) ? (raw_x[9:0] - 10'(X_MAX - X_MIN + 1)) : raw_x[9:0];
  assign spawn_color = (lfsr_q[11:10] == 2'd0) ? 2'd1 : lfsr_q[11:10];
  assign y_next      = {1'b0, y_q} + 11'(FALL_STEP);
  assign lfsr_adv    = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    tick_d     = tick_q;
    lfsr_d     = enable ? lfsr_adv : lfsr_q;
    x_d        = x_q;
    y_d        = y_q;
    color_d    = color_q;
    active_d   = active_q;
    spawned_d  = 1'b0;
    caught_d   = 1'b0;
    missed_d   = 1'b0;
    retire     = 1'b0;

    case (state_q)
      WAIT: begin
        if (enable) begin
          if (wait_cnt_q != '0) begin
            wait_cnt_d = wait_cnt_q - WW'(1);
          end else begin
            x_d       = spawn_x;
            y_d       = 10'(SPAWN_Y);
            color_d   = spawn_color;
            tick_d    = '0;
            active_d  = 1'b1;
            spawned_d = 1'b1;
            state_d   = FALL;
          end
        end
      end
      FALL: begin
        // Collision wins over both pause and the floor step.
        if (collision) begin
          retire   = 1'b1;
          caught_d = 1'b1;
        end else if (enable) begin
          if (tick_q == TW'(TICK_DIV - 1)) begin
            tick_d = '0;
            if (y_next >= 11'(FLOOR_Y)) begin
              retire   = 1'b1;
              missed_d = 1'b1;
            end else begin
              y_d = y_next[9:0];
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      default: state_d = WAIT;
    endcase

    if (retire) begin
      x_d        = PARK;
      y_d        = PARK;
      color_d    = 2'd0;
      active_d   = 1'b0;
      wait_cnt_d = WW'(RESPAWN_DELAY);
      state_d    = WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WAIT;
      wait_cnt_q <= WW'(RESPAWN_DELAY);
      tick_q     <= '0;
      lfsr_q     <= LFSR_SEED;
      x_q        <= PARK;
      y_q        <= PARK;
      color_q    <= 2'd0;
      active_q   <= 1'b0;
      spawned_q  <= 1'b0;
      caught_q   <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      tick_q     <= tick_d;
      lfsr_q     <= lfsr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      color_q    <= color_d;
      active_q   <= active_d;
      spawned_q  <= spawned_d;
      caught_q   <= caught_d;
      missed_q   <= missed_d;
    end
  end

  assign fall_x     = x_q;
  assign fall_y     = y_q;
  assign fall_color = color_q;
  assign active     = active_q;
  assign spawned    = spawned_q;
  assign caught     = caught_q;
  assign missed     = missed_q;

endmodule

// File: tb/tb_falling_block_gen.sv
// Bench for falling_block_gen: fixed reset/spawn table, directed corner sequences,
// and randomized enable/collision traffic against a step-count reference model.
module tb_falling_block_gen;

  localparam int          TD   = 4;
  localparam int          FS   = 2;
  localparam int          SY   = 0;
  localparam int          FY   = 20;
  localparam int          XMIN = 0;
  localparam int          XMAX = 490;
  localparam int          RD   = 3;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [9:0]  PARK = 10'h3FF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       collision = 1'b0;
  logic [9:0] fall_x, fall_y;
  logic [1:0] fall_color;
  logic       active, spawned, caught, missed;

  int n_cmp = 0;
  int n_bad = 0;

  falling_block_gen #(
    .TICK_DIV(TD), .FALL_STEP(FS), .SPAWN_Y(SY), .FLOOR_Y(FY),
    .X_MIN(XMIN), .X_MAX(XMAX), .RESPAWN_DELAY(RD),
    .LFSR_SEED(SEED), .PARK(PARK)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .collision(collision),
    .fall_x(fall_x), .fall_y(fall_y), .fall_color(fall_color),
    .active(active), .spawned(spawned), .caught(caught), .missed(missed)
  );

  always #5 clk = ~clk;

  // Reference model: block height is derived from the number of enabled
  // fall cycles since spawn rather than from a tick counter.
  int          m_wait, m_n;
  logic        m_active, m_sp, m_ca, m_mi;
  logic [9:0]  m_x, m_y;
  logic [1:0]  m_c;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_next(logic [15:0] v);
    logic [15:0] s;
    s = v >> 1;
    return v[0] ? (s ^ 16'hB400) : s;
  endfunction

  task automatic model_park();
    m_active = 1'b0;
    m_x = PARK;
    m_y = PARK;
    m_c = 2'd0;
    m_wait = RD;
  endtask

  task automatic model_edge(logic r, logic e, logic c);
    int raw;
    int ny;
    m_sp = 1'b0; m_ca = 1'b0; m_mi = 1'b0;
    if (r) begin
      model_park();
      m_n = 0;
      m_lfsr = SEED;
      return;
    end
    if (!m_active) begin
      if (e) begin
        if (m_wait > 0) begin
          m_wait--;
        end else begin
          raw = XMIN + int'(m_lfsr[8:0]);
          if (raw > XMAX) raw = raw - (XMAX - XMIN + 1);
          m_x = 10'(raw);
          m_c = (m_lfsr[11:10] == 2'd0) ? 2'd1 : m_lfsr[11:10];
          m_y = 10'(SY);
          m_n = 0;
          m_active = 1'b1;
          m_sp = 1'b1;
        end
      end
    end else if (c) begin
      model_park();
      m_ca = 1'b1;
    end else if (e) begin
      m_n++;
      if (m_n % TD == 0) begin
        ny = SY + FS * (m_n / TD);
        if (ny >= FY) begin
          model_park();
          m_mi = 1'b1;
        end else begin
          m_y = 10'(ny);
        end
      end
    end
    if (e) m_lfsr = lfsr_next(m_lfsr);
  endtask

  function automatic logic [25:0] dut_vec();
    return {fall_x, fall_y, fall_color, active, spawned, caught, missed};
  endfunction

  function automatic logic [25:0] model_vec();
    return {m_x, m_y, m_c, m_active, m_sp, m_ca, m_mi};
  endfunction

  task automatic check(string name, logic [25:0] act, logic [25:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got x=%0d y=%0d c=%0d a/s/k/m=%b, want x=%0d y=%0d c=%0d a/s/k/m=%b",
               name, act[25:16], act[15:6], act[5:4], act[3:0],
               exp[25:16], exp[15:6], exp[5:4], exp[3:0]);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic step(logic r, logic e, logic c);
    rst = r; enable = e; collision = c;
    model_edge(r, e, c);
    @(posedge clk);
    #1;
  endtask

  task automatic run_model(string name, logic r, logic e, logic c);
    step(r, e, c);
    check(name, dut_vec(), model_vec());
    $display("%s: x=%0d y=%0d c=%0d a/s/k/m=%b%b%b%b", name, fall_x, fall_y, fall_color,
             active, spawned, caught, missed);
  endtask

  // Runs enabled, collision-free cycles until the model reaches row target
  // (and tick phase tick_mod when >= 0).
  task automatic wait_y(string name, int target, int tick_mod);
    int k;
    for (k = 0; k < 300; k++) begin
      if (m_active && int'(m_y) == target && (tick_mod < 0 || (m_n % TD) == tick_mod)) break;
      run_model(name, 1'b0, 1'b1, 1'b0);
    end
    if (k == 300) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: timeout waiting for y=%0d", name, target);
    end
  endtask

  typedef struct {
    logic       r, e, c;
    logic [9:0] x, y;
    logic [1:0] col;
    logic       a, s, k, m;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mk(logic r, logic [9:0] x, logic [9:0] y, logic [1:0] col,
                              logic a, logic s);
    vec_t v;
    v.r = r; v.e = 1'b1; v.c = 1'b0;
    v.x = x; v.y = y; v.col = col;
    v.a = a; v.s = s; v.k = 1'b0; v.m = 1'b0;
    return v;
  endfunction

  task automatic run_table(string tag);
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].c);
      check($sformatf("%s[%0d]", tag, i), dut_vec(),
            {tbl[i].x, tbl[i].y, tbl[i].col, tbl[i].a, tbl[i].s, tbl[i].k, tbl[i].m});
      $display("%s[%0d]: x=%0d y=%0d c=%0d a/s/k/m=%b%b%b%b", tag, i, fall_x, fall_y,
               fall_color, active, spawned, caught, missed);
    end
  endtask

  initial begin
    int fc;
    int cnt;
    int spawns;
    int cyc;
    logic [9:0] y0;
    logic e;
    logic c;

    // Seed ACE1 advances to 389C after three enabled cycles: x=0x09C=156, color=2.
    tbl[0] = mk(1'b1, PARK, PARK, 2'd0, 1'b0, 1'b0);
    tbl[1] = mk(1'b0, PARK, PARK, 2'd0, 1'b0, 1'b0);
    tbl[2] = mk(1'b0, PARK, PARK, 2'd0, 1'b0, 1'b0);
    tbl[3] = mk(1'b0, PARK, PARK, 2'd0, 1'b0, 1'b0);
    tbl[4] = mk(1'b0, 10'd156, 10'd0, 2'd2, 1'b1, 1'b1);
    tbl[5] = mk(1'b0, 10'd156, 10'd0, 2'd2, 1'b1, 1'b0);
    tbl[6] = mk(1'b0, 10'd156, 10'd0, 2'd2, 1'b1, 1'b0);
    tbl[7] = mk(1'b0, 10'd156, 10'd0, 2'd2, 1'b1, 1'b0);
    tbl[8] = mk(1'b0, 10'd156, 10'd2, 2'd2, 1'b1, 1'b0);
    tbl[9] = mk(1'b0, 10'd156, 10'd2, 2'd2, 1'b1, 1'b0);

    run_model("reset_state", 1'b1, 1'b0, 1'b0);
    run_table("rst_seq");

    // Uncaught descent: the miss lands on the 40th fall cycle.
    fc = 5;
    for (int k = 0; k < 60; k++) begin
      run_model("descent", 1'b0, 1'b1, 1'b0);
      fc++;
      if (missed) break;
    end
    check_int("miss_cycle", fc, 40);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      run_model("respawn", 1'b0, 1'b1, 1'b0);
      cnt++;
      if (spawned) break;
    end
    check_int("respawn_gap", cnt, RD + 1);

    // Caught at y=6, then collision held through the whole respawn wait.
    wait_y("to_y6", 6, -1);
    run_model("catch_y6", 1'b0, 1'b1, 1'b1);
    check_int("catch_pulse", int'({caught, missed, active}), 3'b100);
    for (int k = 0; k < RD + 1; k++) run_model("col_held", 1'b0, 1'b1, 1'b1);
    check_int("respawn_under_col", int'({active, spawned}), 2'b11);

    // Collision on the same edge as the floor step.
    wait_y("to_floor", 18, TD - 1);
    run_model("catch_floor", 1'b0, 1'b1, 1'b1);
    check_int("catch_not_miss", int'({caught, missed}), 2'b10);
    wait_y("to_respawn", SY, -1);

    // Pause mid-fall with one tick already spent.
    wait_y("to_pause", 6, 1);
    y0 = fall_y;
    for (int k = 0; k < 20; k++) run_model("pause", 1'b0, 1'b0, 1'b0);
    check_int("pause_hold", int'(fall_y), int'(y0));
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      run_model("resume", 1'b0, 1'b1, 1'b0);
      cnt++;
      if (fall_y != y0) break;
    end
    check_int("resume_ticks", cnt, TD - 1);
    run_model("pause2", 1'b0, 1'b0, 1'b0);
    run_model("pause_col", 1'b0, 1'b0, 1'b1);
    check_int("pause_caught", int'({caught, active}), 2'b10);

    // Reset mid-fall replays the power-on sequence exactly.
    wait_y("to_y10", 10, -1);
    run_table("rst_mid");

    // Random stall/collision traffic.
    spawns = 0;
    cyc = 0;
    while (spawns < 1000 && cyc < 90000) begin
      e = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 19) == 0);
      step(1'b0, e, c);
      check("random", dut_vec(), model_vec());
      if (spawned) spawns++;
      if (active) begin
        n_cmp++;
        if (int'(fall_x) < XMIN || int'(fall_x) > XMAX || fall_color == 2'd0) begin
          n_bad++;
          $display("FAIL random_range: got x=%0d color=%0d, want x in [%0d,%0d] color 1..3",
                   fall_x, fall_color, XMIN, XMAX);
        end
      end
      cyc++;
    end
    $display("random: %0d spawns in %0d cycles", spawns, cyc);
    check_int("random_spawns", spawns, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
